// File: rtl/frame_stream_pkg.sv
// Shared types for the sample frame streamer: default sizes, FSM state codes
// and the frame buffer layout (tag followed by the channel words).
package frame_stream_pkg;

    localparam int NUM_CH_DEF = 8;
    localparam int DATA_W_DEF = 32;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HEADER = 2'd1;
    localparam logic [1:0] ST_DATA   = 2'd2;
    localparam logic [1:0] ST_CHECK  = 2'd3;

    typedef struct packed {
        logic [DATA_W_DEF-1:0]                 tag;
        logic [NUM_CH_DEF-1:0][DATA_W_DEF-1:0] ch;
    } frame_t;

endpackage

// File: rtl/frame_buffer_slot.sv
// One frame of storage with a valid flag; load takes priority over clear so a
// slot can be emptied and refilled in the same cycle.
module frame_buffer_slot
    import frame_stream_pkg::*;
#(
    parameter type slot_t = frame_t
) (
    input  logic  clk,
    input  logic  rst_ni,
    input  logic  load_i,
    input  logic  clear_i,
    input  slot_t data_i,
    output logic  valid_o,
    output slot_t data_o
);

    logic  valid_q, valid_d;
    slot_t data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/sample_frame_streamer.sv
// Captures a channel snapshot whenever the sync tag changes and streams it as
// tag + channel words. FRAME_CHECKSUM_EN appends an XOR checksum word.
module sample_frame_streamer
    import frame_stream_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                           clk,
    input  logic                           rst_ni,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  ch_i,
    input  logic [DATA_W-1:0]              sync_i,
    input  logic                           enable_i,
    output logic [DATA_W-1:0]              m_tdata_o,
    output logic                           m_tvalid_o,
    input  logic                           m_tready_i,
    output logic                           m_tlast_o,
    output logic [15:0]                    drop_cnt_o,
    output logic                           busy_o
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    typedef struct packed {
        logic [DATA_W-1:0]             tag;
        logic [NUM_CH-1:0][DATA_W-1:0] ch;
    } buf_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] sync_q, sync_d;
    logic [15:0]       drop_q, drop_d;

    buf_t snap, act_in, act_buf, pend_buf;
    logic act_v, pend_v;
    logic act_load, act_clear, act_from_pend, pend_load, pend_clear;
    logic frame_evt, hs, done, act_free;

    assign frame_evt = enable_i && (sync_i != sync_q);
    assign hs        = m_tvalid_o && m_tready_i;
    assign done      = hs && m_tlast_o;
    assign act_free  = !act_v || done;
    assign sync_d    = sync_i;

    always_comb begin
        snap.tag = sync_i;
        snap.ch  = ch_i;
        act_in   = act_from_pend ? pend_buf : snap;
    end

    frame_buffer_slot #(.slot_t(buf_t)) u_active (
        .clk     (clk),
        .rst_ni  (rst_ni),
        .load_i  (act_load),
        .clear_i (act_clear),
        .data_i  (act_in),
        .valid_o (act_v),
        .data_o  (act_buf)
    );

    frame_buffer_slot #(.slot_t(buf_t)) u_pending (
        .clk     (clk),
        .rst_ni  (rst_ni),
        .load_i  (pend_load),
        .clear_i (pend_clear),
        .data_i  (snap),
        .valid_o (pend_v),
        .data_o  (pend_buf)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        drop_d        = drop_q;
        act_load      = 1'b0;
        act_clear     = 1'b0;
        act_from_pend = 1'b0;
        pend_load     = 1'b0;
        pend_clear    = 1'b0;

        case (state_q)
            ST_HEADER: if (hs) begin
                state_d = ST_DATA;
                idx_d   = '0;
            end
            ST_DATA: if (hs) begin
                if (idx_q == LAST_IDX) begin
`ifdef FRAME_CHECKSUM_EN
                    state_d = ST_CHECK;
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: ;
        endcase

        // The final handshake frees the active slot before the event is judged.
        if (act_free) begin
            if (pend_v) begin
                act_load      = 1'b1;
                act_from_pend = 1'b1;
                pend_clear    = 1'b1;
                pend_load     = frame_evt;
                state_d       = ST_HEADER;
            end else if (frame_evt) begin
                act_load = 1'b1;
                state_d  = ST_HEADER;
            end else begin
                act_clear = 1'b1;
                state_d   = ST_IDLE;
            end
        end else if (frame_evt) begin
            if (!pend_v) begin
                pend_load = 1'b1;
            end else if (drop_q != 16'hFFFF) begin
                drop_d = drop_q + 16'd1;
            end
        end
    end

`ifdef FRAME_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
    always_comb begin
        csum = act_buf.tag;
        for (int i = 0; i < NUM_CH; i++) begin
            csum = csum ^ act_buf.ch[i];
        end
    end
`endif

    always_comb begin
        m_tvalid_o = (state_q != ST_IDLE);
        m_tdata_o  = '0;
        m_tlast_o  = 1'b0;
        case (state_q)
            ST_HEADER: m_tdata_o = act_buf.tag;
            ST_DATA: begin
                m_tdata_o = act_buf.ch[idx_q];
`ifndef FRAME_CHECKSUM_EN
                m_tlast_o = (idx_q == LAST_IDX);
`endif
            end
            ST_CHECK: begin
`ifdef FRAME_CHECKSUM_EN
                m_tdata_o = csum;
                m_tlast_o = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            sync_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sync_q  <= sync_d;
            drop_q  <= drop_d;
        end
    end

    assign drop_cnt_o = drop_q;
    assign busy_o     = (state_q != ST_IDLE) || pend_v;

endmodule
